// File: rtl/counter_cmd_pkg.sv
// Shared types and defaults for the command-counter controller and its helpers.
// Holds the FSM encoding, parameter defaults and the index-width helper.
package counter_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CMD     = 2'd1,
      LOCKOUT = 2'd2
   } state_t;

   localparam int DEF_NUM_CMD        = 3;
   localparam int DEF_EXCLUSIVE      = 1;
   localparam int DEF_LOCKOUT_CYCLES = 0;
   localparam int CNT_W              = 16;

   // A single channel still needs a one-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cmd_prio_enc.sv
// Lowest-index priority encoder: idx is the lowest set request bit, any flags a request.
module cmd_prio_enc #(
   parameter int NUM_CMD = 3,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_CMD-1:0] req,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   // Scan from the top down so the lowest set bit is written last and wins.
   always_comb begin
      idx = '0;
      for (int k = NUM_CMD - 1; k >= 0; k--) begin
         if (req[k]) idx = IDX_W'(k);
      end
   end

   assign any = |req;

endmodule

// File: rtl/counter_cmd_controller.sv
// Edge-triggered command controller: one accepted rise per operation, toggle or pulse
// channel outputs, optional exclusivity and a post-command lockout window.
module counter_cmd_controller
   import counter_cmd_pkg::*;
#(
   parameter int                 NUM_CMD        = DEF_NUM_CMD,
   parameter logic [NUM_CMD-1:0] PULSE_MASK     = '0,
   parameter int                 EXCLUSIVE      = DEF_EXCLUSIVE,
   parameter int                 LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
   localparam int                IDX_W          = idx_width(NUM_CMD)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_CMD-1:0] cmd_in,
   output logic [NUM_CMD-1:0] o_state,
   output logic               o_valid,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_busy,
   output logic               o_drop,
   output logic [1:0]         dbg_state
);

   // o_valid is a one-cycle strobe qualifying o_idx; there is no ready, so the
   // consumer must take the update on the cycle it is presented.

   state_t             state;
   logic [NUM_CMD-1:0] cmd_d;
   logic [NUM_CMD-1:0] rise;
   logic [NUM_CMD-1:0] hold;
   logic [NUM_CMD-1:0] upd;
   logic               multi;
   logic [IDX_W-1:0]   pend_idx;
   logic [IDX_W-1:0]   enc_idx;
   logic               enc_any;
   logic [CNT_W-1:0]   cnt;

   assign rise      = cmd_in & ~cmd_d;
   assign hold      = o_state & ~PULSE_MASK;
   assign multi     = |(rise & (rise - NUM_CMD'(1)));
   assign o_busy    = (state != IDLE);
   assign dbg_state = state;

   cmd_prio_enc #(
      .NUM_CMD (NUM_CMD),
      .IDX_W   (IDX_W)
   ) u_prio_enc (
      .req (rise),
      .idx (enc_idx),
      .any (enc_any)
   );

   // Pulse bits self-clear every cycle; the selected channel toggles or pulses.
   always_comb begin
      upd = hold;
      for (int k = 0; k < NUM_CMD; k++) begin
         if (k == int'(pend_idx)) begin
            upd[k] = PULSE_MASK[k] ? 1'b1 : ~o_state[k];
         end else if (EXCLUSIVE != 0) begin
            upd[k] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cmd_d    <= '0;
         o_state  <= '0;
         o_valid  <= 1'b0;
         o_idx    <= '0;
         o_drop   <= 1'b0;
         pend_idx <= '0;
         cnt      <= '0;
      end else begin
         cmd_d   <= cmd_in;
         o_valid <= 1'b0;
         o_drop  <= 1'b0;
         o_state <= hold;
         case (state)
            IDLE: begin
               if (enc_any) begin
                  pend_idx <= enc_idx;
                  o_drop   <= multi;
                  state    <= CMD;
               end
            end
            CMD: begin
               o_state <= upd;
               o_valid <= 1'b1;
               o_idx   <= pend_idx;
               o_drop  <= |rise;
               if (LOCKOUT_CYCLES > 0) begin
                  cnt   <= CNT_W'(LOCKOUT_CYCLES);
                  state <= LOCKOUT;
               end else begin
                  state <= IDLE;
               end
            end
            LOCKOUT: begin
               o_drop <= |rise;
               cnt    <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_cmd_controller.sv
// Directed plus random bench for counter_cmd_controller over five parameter sets,
// every DUT compared each cycle against a transaction-level reference model.
module tb_counter_cmd_controller;

   localparam int NDUT = 5;
   localparam logic [2:0] PM [NDUT] = '{3'b000, 3'b000, 3'b010, 3'b000, 3'b101};
   localparam int         EX [NDUT] = '{1, 0, 1, 1, 0};
   localparam int         LK [NDUT] = '{0, 0, 0, 4, 2};

   logic       clk;
   logic       rst;
   logic [2:0] cmd;

   logic [2:0] d_state [NDUT];
   logic       d_valid [NDUT];
   logic [1:0] d_idx   [NDUT];
   logic       d_busy  [NDUT];
   logic       d_drop  [NDUT];
   logic [1:0] d_dbg   [NDUT];

   int tests;
   int fails;

   // reference model: busy_left counts the cycles the controller still refuses rises
   logic [2:0] m_state [NDUT];
   logic       m_valid [NDUT];
   logic [1:0] m_idx   [NDUT];
   logic       m_drop  [NDUT];
   logic [2:0] m_prev  [NDUT];
   logic [1:0] m_pend  [NDUT];
   logic       m_has_pend [NDUT];
   int         m_left  [NDUT];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   counter_cmd_controller u0 (
      .clk(clk), .rst(rst), .cmd_in(cmd), .o_state(d_state[0]), .o_valid(d_valid[0]),
      .o_idx(d_idx[0]), .o_busy(d_busy[0]), .o_drop(d_drop[0]), .dbg_state(d_dbg[0]));

   counter_cmd_controller #(.EXCLUSIVE(0)) u1 (
      .clk(clk), .rst(rst), .cmd_in(cmd), .o_state(d_state[1]), .o_valid(d_valid[1]),
      .o_idx(d_idx[1]), .o_busy(d_busy[1]), .o_drop(d_drop[1]), .dbg_state(d_dbg[1]));

   counter_cmd_controller #(.PULSE_MASK(3'b010)) u2 (
      .clk(clk), .rst(rst), .cmd_in(cmd), .o_state(d_state[2]), .o_valid(d_valid[2]),
      .o_idx(d_idx[2]), .o_busy(d_busy[2]), .o_drop(d_drop[2]), .dbg_state(d_dbg[2]));

   counter_cmd_controller #(.LOCKOUT_CYCLES(4)) u3 (
      .clk(clk), .rst(rst), .cmd_in(cmd), .o_state(d_state[3]), .o_valid(d_valid[3]),
      .o_idx(d_idx[3]), .o_busy(d_busy[3]), .o_drop(d_drop[3]), .dbg_state(d_dbg[3]));

   counter_cmd_controller #(.PULSE_MASK(3'b101), .EXCLUSIVE(0), .LOCKOUT_CYCLES(2)) u4 (
      .clk(clk), .rst(rst), .cmd_in(cmd), .o_state(d_state[4]), .o_valid(d_valid[4]),
      .o_idx(d_idx[4]), .o_busy(d_busy[4]), .o_drop(d_drop[4]), .dbg_state(d_dbg[4]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < NDUT; i++) begin
         if (rst) begin
            m_state[i] = '0; m_valid[i] = 1'b0; m_idx[i] = '0; m_drop[i] = 1'b0;
            m_prev[i] = '0; m_pend[i] = '0; m_has_pend[i] = 1'b0; m_left[i] = 0;
         end else begin
            logic [2:0] rises;
            int nr;
            rises = cmd & ~m_prev[i];
            m_state[i] = m_state[i] & ~PM[i];
            m_valid[i] = 1'b0;
            if (m_has_pend[i]) begin
               for (int k = 0; k < 3; k++) begin
                  if (k == int'(m_pend[i])) m_state[i][k] = PM[i][k] ? 1'b1 : ~m_state[i][k];
                  else if (EX[i] != 0) m_state[i][k] = 1'b0;
               end
               m_valid[i] = 1'b1;
               m_idx[i] = m_pend[i];
               m_has_pend[i] = 1'b0;
            end
            if (m_left[i] == 0) begin
               nr = $countones(rises);
               m_drop[i] = (nr > 1);
               if (nr > 0) begin
                  m_pend[i] = rises[0] ? 2'd0 : (rises[1] ? 2'd1 : 2'd2);
                  m_has_pend[i] = 1'b1;
                  m_left[i] = 1 + LK[i];
               end
            end else begin
               m_drop[i] = (rises != 0);
               m_left[i] = m_left[i] - 1;
            end
            m_prev[i] = cmd;
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < NDUT; i++) begin
         logic [1:0] exp_dbg;
         exp_dbg = m_has_pend[i] ? 2'd1 : ((m_left[i] > 0) ? 2'd2 : 2'd0);
         check($sformatf("u%0d_state", i), d_state[i], m_state[i]);
         check($sformatf("u%0d_valid", i), d_valid[i], m_valid[i]);
         check($sformatf("u%0d_idx", i), d_idx[i], m_idx[i]);
         check($sformatf("u%0d_busy", i), d_busy[i], m_left[i] > 0);
         check($sformatf("u%0d_drop", i), d_drop[i], m_drop[i]);
         check($sformatf("u%0d_dbg", i), d_dbg[i], exp_dbg);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic drain(input int n);
      cmd = 3'b000;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int busy_cnt;
      int drop_cnt;
      tests = 0;
      fails = 0;
      rst = 1'b1;
      cmd = 3'b000;
      tick();
      tick();
      check("rst_state", d_state[0], 3'b000);
      check("rst_busy", d_busy[0], 1'b0);
      rst = 1'b0;

      // single rise, then a second rise toggles back
      cmd = 3'b001; tick();
      check("r033_busy", d_busy[0], 1'b1);
      check("r033_early_valid", d_valid[0], 1'b0);
      tick();
      check("r033_state", d_state[0], 3'b001);
      check("r033_valid", d_valid[0], 1'b1);
      check("r033_idx", d_idx[0], 2'd0);
      cmd = 3'b000; tick();
      check("r033_valid_one", d_valid[0], 1'b0);
      cmd = 3'b001; tick(); tick();
      check("r033_toggle_back", d_state[0], 3'b000);
      drain(6);

      // coincident rises: lowest wins, the other is dropped
      cmd = 3'b110; tick();
      check("r034_drop", d_drop[0], 1'b1);
      tick();
      check("r034_idx", d_idx[0], 2'd1);
      check("r034_state", d_state[0], 3'b010);
      check("r034_drop_once", d_drop[0], 1'b0);

      // exclusive versus non-exclusive
      rst = 1'b1; cmd = 3'b000; tick(); rst = 1'b0;
      cmd = 3'b001; tick(); tick();
      check("r035_pre", d_state[0], 3'b001);
      cmd = 3'b000; tick();
      cmd = 3'b100; tick(); tick();
      check("r035_excl", d_state[0], 3'b100);
      check("r035_nonexcl", d_state[1], 3'b101);
      drain(6);

      // pulse channel held high never re-fires
      cmd = 3'b010; tick(); tick();
      check("r036_pulse_hi", d_state[2][1], 1'b1);
      tick();
      check("r036_pulse_lo", d_state[2][1], 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("r036_hold_valid", d_valid[2], 1'b0);
         check("r036_hold_state", d_state[2][1], 1'b0);
      end

      // lockout window drops a later rise
      rst = 1'b1; cmd = 3'b000; tick(); rst = 1'b0;
      tick();
      busy_cnt = 0;
      drop_cnt = 0;
      cmd = 3'b001;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) cmd = 3'b011;
         tick();
         if (d_busy[3]) busy_cnt++;
         if (d_drop[3]) drop_cnt++;
      end
      check("r037_busy_cycles", busy_cnt, 5);
      check("r037_drop_count", drop_cnt, 1);
      check("r037_state", d_state[3], 3'b001);

      // reset mid-lockout, then a held input counts as a rise
      cmd = 3'b000; tick();
      cmd = 3'b001; tick(); tick(); tick();
      check("r038_in_lockout", d_dbg[3], 2'd2);
      cmd = 3'b010; rst = 1'b1; tick();
      check("r038_state", d_state[3], 3'b000);
      check("r038_valid", d_valid[3], 1'b0);
      check("r038_busy", d_busy[3], 1'b0);
      check("r038_dbg", d_dbg[3], 2'd0);
      rst = 1'b0; tick();
      check("r038_accept", d_dbg[3], 2'd1);
      tick();
      check("r038_new_state", d_state[3], 3'b010);
      check("r038_new_idx", d_idx[3], 2'd1);

      // random traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) != 0) cmd = 3'($urandom_range(0, 7));
         rst = ($urandom_range(0, 59) == 0);
         tick();
      end
      rst = 1'b0;
      drain(8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
